// File: rtl/jtopll_wrq_pkg.sv
// Shared state encoding and default YM2413 bus timing for the jtopll write queue.
package jtopll_wrq_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADR   = 3'd1;
  localparam logic [2:0] AWAIT = 3'd2;
  localparam logic [2:0] DAT   = 3'd3;
  localparam logic [2:0] DWAIT = 3'd4;

  localparam int DEF_STROBE    = 2;
  localparam int DEF_ADDR_WAIT = 12;
  localparam int DEF_DATA_WAIT = 84;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jtopl_fifo.sv
// Generic synchronous FIFO with occupancy count; first word is visible on dout while not empty.
module jtopl_fifo #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          do_push;
  logic          do_pop;

  // level never exceeds 2**AW, so its top bit alone marks a full queue
  assign full    = level_reg[AW];
  assign empty   = (level_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      level_reg <= level_reg + 1'b1;
      else if (do_pop && !do_push) level_reg <= level_reg - 1'b1;
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign level = level_reg;

endmodule

// File: rtl/jtopll_wrq.sv
// Queues host (reg,val) writes and replays them on the jtopll bus with YM2413 wait times.
// Optional JTOPLL_WRQ_SKIPADR_EN skips the address cycle when the register repeats.
module jtopll_wrq
  import jtopll_wrq_pkg::*;
#(
  parameter int AW        = 4,
  parameter int STROBE    = DEF_STROBE,
  parameter int ADDR_WAIT = DEF_ADDR_WAIT,
  parameter int DATA_WAIT = DEF_DATA_WAIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [7:0]  wr_reg,
  input  logic [7:0]  wr_val,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  din,
  output logic        addr,
  output logic        cs_n,
  output logic        wr_n,
  output logic        busy,
  output logic [AW:0] level
);

  localparam int CW = $clog2(max3(STROBE, ADDR_WAIT, DATA_WAIT) + 1);
  localparam logic [CW-1:0] CNT_STROBE    = CW'(STROBE);
  localparam logic [CW-1:0] CNT_ADDR_WAIT = CW'(ADDR_WAIT);
  localparam logic [CW-1:0] CNT_DATA_WAIT = CW'(DATA_WAIT);

  logic          push;
  logic          pop;
  logic [15:0]   fifo_dout;
  logic [AW:0]   fifo_level;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   level_next;

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          last_tick;
  logic [7:0]    hold_addr_reg;
  logic [7:0]    hold_val_reg;
  logic          wr_ready_reg;
  logic          cs_n_reg;
  logic          wr_n_reg;
  logic          addr_reg;
  logic [7:0]    din_reg;

`ifdef JTOPLL_WRQ_SKIPADR_EN
  logic [7:0]    last_reg_reg;
  logic          last_ok_reg;
`endif

  assign push = wr_valid & wr_ready_reg & ~fifo_full;

  jtopl_fifo #(
    .DW (16),
    .AW (AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({wr_reg, wr_val}),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Occupancy after this edge; ready is registered from it so pop never reaches ready combinationally
  always_comb begin
    level_next = fifo_level;
    if (push && !pop)      level_next = fifo_level + 1'b1;
    else if (pop && !push) level_next = fifo_level - 1'b1;
  end

  assign last_tick = (cnt_reg == CW'(1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pop        = 1'b0;
    if (cen) begin
      if (state_reg != IDLE) cnt_next = cnt_reg - 1'b1;
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ADR;
            cnt_next   = CNT_STROBE;
`ifdef JTOPLL_WRQ_SKIPADR_EN
            if (last_ok_reg && fifo_dout[15:8] == last_reg_reg) state_next = DAT;
`endif
          end
        end
        ADR:   if (last_tick) begin state_next = AWAIT; cnt_next = CNT_ADDR_WAIT; end
        AWAIT: if (last_tick) begin state_next = DAT;   cnt_next = CNT_STROBE;    end
        DAT:   if (last_tick) begin state_next = DWAIT; cnt_next = CNT_DATA_WAIT; end
        DWAIT: if (last_tick) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Bus pins are a registered decode of the current state, so they trail the state by one tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      hold_addr_reg <= '0;
      hold_val_reg  <= '0;
      wr_ready_reg  <= 1'b0;
      cs_n_reg      <= 1'b1;
      wr_n_reg      <= 1'b1;
      addr_reg      <= 1'b0;
      din_reg       <= '0;
    end else begin
      wr_ready_reg <= ~level_next[AW];
      if (cen) begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        if (pop) begin
          hold_addr_reg <= fifo_dout[15:8];
          hold_val_reg  <= fifo_dout[7:0];
        end
        case (state_reg)
          ADR: begin
            cs_n_reg <= 1'b0;
            wr_n_reg <= 1'b0;
            addr_reg <= 1'b0;
            din_reg  <= hold_addr_reg;
          end
          DAT: begin
            cs_n_reg <= 1'b0;
            wr_n_reg <= 1'b0;
            addr_reg <= 1'b1;
            din_reg  <= hold_val_reg;
          end
          default: begin
            cs_n_reg <= 1'b1;
            wr_n_reg <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef JTOPLL_WRQ_SKIPADR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_reg_reg <= '0;
      last_ok_reg  <= 1'b0;
    end else if (cen && state_reg == ADR && last_tick) begin
      last_reg_reg <= hold_addr_reg;
      last_ok_reg  <= 1'b1;
    end
  end
`endif

  assign wr_ready = wr_ready_reg;
  assign din      = din_reg;
  assign addr     = addr_reg;
  assign cs_n     = cs_n_reg;
  assign wr_n     = wr_n_reg;
  assign busy     = (state_reg != IDLE) || (fifo_level != '0);
  assign level    = fifo_level;

endmodule

// File: tb/tb_jtopll_wrq.sv
// Directed bench for jtopll_wrq: vector table for one write plus burst, cen, reset and repeat-register sequences.
module tb_jtopll_wrq;

  typedef struct {
    int         k;
    logic       cs_n;
    logic       wr_n;
    logic       addr;
    logic [7:0] din;
    logic       busy;
    logic [4:0] level;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen;
  logic [7:0] wr_reg = 8'h00;
  logic [7:0] wr_val = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] din;
  logic       addr;
  logic       cs_n;
  logic       wr_n;
  logic       busy;
  logic [4:0] level;

  logic [1:0] cen_mode = 2'd1;
  logic [1:0] div_cnt = 2'd0;

  int tests = 0;
  int fails = 0;

  jtopll_wrq #(.AW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .wr_reg   (wr_reg),
    .wr_val   (wr_val),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .din      (din),
    .addr     (addr),
    .cs_n     (cs_n),
    .wr_n     (wr_n),
    .busy     (busy),
    .level    (level)
  );

  always #5 clk = ~clk;

  // cen_mode: 0 = held low, 1 = held high, 2 = one tick in four
  always @(posedge clk) div_cnt <= div_cnt + 2'd1;
  assign cen = (cen_mode == 2'd2) ? (div_cnt == 2'd0) : cen_mode[0];

  // Bus monitor: logs strobe starts and measures low times and the address-to-data gap
  int   cyc = 0;
  logic prev_cs_n = 1'b1;
  int   fall_cyc = 0;
  int   rise_cyc = 0;
  int   a_din_q[$];
  int   a_cyc_q[$];
  int   d_din_q[$];
  int   d_cyc_q[$];
  int   a_dur_q[$];
  int   d_dur_q[$];
  int   gap_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      if (prev_cs_n && !cs_n) begin
        fall_cyc = cyc;
        if (!addr) begin
          a_din_q.push_back(int'(din));
          a_cyc_q.push_back(cyc);
        end else begin
          d_din_q.push_back(int'(din));
          d_cyc_q.push_back(cyc);
          gap_q.push_back(cyc - rise_cyc);
        end
        $display("[TB] bus cycle addr=%b din=%02h at cycle %0d", addr, din, cyc);
      end else if (!prev_cs_n && cs_n) begin
        rise_cyc = cyc;
        if (!addr) a_dur_q.push_back(cyc - fall_cyc);
        else       d_dur_q.push_back(cyc - fall_cyc);
      end
    end
    prev_cs_n = cs_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    a_din_q.delete(); a_cyc_q.delete(); d_din_q.delete(); d_cyc_q.delete();
    a_dur_q.delete(); d_dur_q.delete(); gap_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_mon();
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] v);
    @(negedge clk);
    wr_reg = r;
    wr_val = v;
    wr_valid = 1'b1;
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    int   vi;

    // Single write 0x10/0x5A; k = cycles after the accepting edge
    vecs[0]  = '{0,   1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 5'd1};
    vecs[1]  = '{1,   1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 5'd0};
    vecs[2]  = '{2,   1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 5'd0};
    vecs[3]  = '{3,   1'b0, 1'b0, 1'b0, 8'h10, 1'b1, 5'd0};
    vecs[4]  = '{4,   1'b1, 1'b1, 1'b0, 8'h10, 1'b1, 5'd0};
    vecs[5]  = '{15,  1'b1, 1'b1, 1'b0, 8'h10, 1'b1, 5'd0};
    vecs[6]  = '{16,  1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 5'd0};
    vecs[7]  = '{17,  1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 5'd0};
    vecs[8]  = '{18,  1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 5'd0};
    vecs[9]  = '{100, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 5'd0};
    vecs[10] = '{101, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 5'd0};

    // Reset state
    cen_mode = 2'd1;
    repeat (3) @(negedge clk);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_cs_n",     32'(cs_n),     32'd1);
    check("rst_wr_n",     32'(wr_n),     32'd1);
    check("rst_addr",     32'(addr),     32'd0);
    check("rst_din",      32'(din),      32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_level",    32'(level),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(wr_ready), 32'd1);

    // Table-driven single write
    push(8'h10, 8'h5A);
    vi = 0;
    for (int k = 0; k <= 101; k++) begin
      @(negedge clk);
      if (vi < 11 && vecs[vi].k == k) begin
        $display("[TB] vec k=%0d cs_n=%b wr_n=%b addr=%b din=%02h busy=%b level=%0d",
                 k, cs_n, wr_n, addr, din, busy, level);
        check($sformatf("v%0d_cs_n", k),  32'(cs_n),  32'(vecs[vi].cs_n));
        check($sformatf("v%0d_wr_n", k),  32'(wr_n),  32'(vecs[vi].wr_n));
        check($sformatf("v%0d_addr", k),  32'(addr),  32'(vecs[vi].addr));
        check($sformatf("v%0d_din", k),   32'(din),   32'(vecs[vi].din));
        check($sformatf("v%0d_busy", k),  32'(busy),  32'(vecs[vi].busy));
        check($sformatf("v%0d_level", k), 32'(level), 32'(vecs[vi].level));
        vi++;
      end
    end

    // Burst of 17 with the FSM stalled: fill, then push and pop at full
    do_reset();
    cen_mode = 2'd0;
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i), 8'(8'hA0 + i));
    @(negedge clk);
    check("full_level", 32'(level),    32'd16);
    check("full_ready", 32'(wr_ready), 32'd0);
    wr_reg = 8'h40;
    wr_val = 8'hB0;
    wr_valid = 1'b1;
    cen_mode = 2'd1;
    @(negedge clk);
    check("pushpop_level", 32'(level),    32'd15);
    check("pushpop_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    check("refill_level", 32'(level),    32'd16);
    check("refill_ready", 32'(wr_ready), 32'd0);
    wr_valid = 1'b0;
    wait_idle(2500, "burst_idle_timeout");
    $display("[TB] burst done: %0d address cycles, %0d data cycles", a_din_q.size(), d_din_q.size());
    check("burst_a_count", 32'(a_din_q.size()), 32'd17);
    check("burst_d_count", 32'(d_din_q.size()), 32'd17);
    for (int i = 0; i < 17 && i < a_din_q.size() && i < d_din_q.size(); i++) begin
      check($sformatf("burst_reg%0d", i), 32'(a_din_q[i]), 32'(8'h30 + i));
      check($sformatf("burst_val%0d", i), 32'(d_din_q[i]), 32'(8'hA0 + i));
      if (i > 0) check($sformatf("burst_space%0d", i), 32'(a_cyc_q[i] - a_cyc_q[i-1]), 32'd101);
    end
    if (a_dur_q.size() > 0) check("burst_adur", 32'(a_dur_q[0]), 32'd2);
    if (d_dur_q.size() > 0) check("burst_ddur", 32'(d_dur_q[0]), 32'd2);
    if (gap_q.size() > 0)   check("burst_gap",  32'(gap_q[0]),   32'd12);

    // cen at one tick in four; pushes taken while cen is held low
    do_reset();
    cen_mode = 2'd0;
    push(8'h50, 8'hC0);
    check("cen0_level1", 32'(level), 32'd1);
    push(8'h51, 8'hC1);
    check("cen0_level2", 32'(level), 32'd2);
    cen_mode = 2'd2;
    wait_idle(1200, "cen4_idle_timeout");
    $display("[TB] cen/4 done: %0d address cycles", a_din_q.size());
    check("cen4_a_count", 32'(a_din_q.size()), 32'd2);
    check("cen4_d_count", 32'(d_din_q.size()), 32'd2);
    if (a_din_q.size() == 2 && d_din_q.size() == 2) begin
      check("cen4_reg0", 32'(a_din_q[0]), 32'h50);
      check("cen4_reg1", 32'(a_din_q[1]), 32'h51);
      check("cen4_val1", 32'(d_din_q[1]), 32'hC1);
      check("cen4_space", 32'(a_cyc_q[1] - a_cyc_q[0]), 32'd404);
      check("cen4_adur", 32'(a_dur_q[0]), 32'd8);
      check("cen4_ddur", 32'(d_dur_q[0]), 32'd8);
      check("cen4_gap",  32'(gap_q[0]),   32'd48);
    end

    // Reset in DWAIT of the first write with three entries still queued
    do_reset();
    cen_mode = 2'd1;
    push(8'h20, 8'h11);
    push(8'h22, 8'h12);
    push(8'h23, 8'h13);
    push(8'h24, 8'h14);
    check("midrst_level_before", 32'(level), 32'd3);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cs_n",  32'(cs_n),  32'd1);
    check("midrst_wr_n",  32'(wr_n),  32'd1);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_busy",  32'(busy),  32'd0);
    rst_n = 1'b1;
    clear_mon();
    repeat (300) @(negedge clk);
    $display("[TB] after mid-transfer reset: %0d bus cycles", a_din_q.size() + d_din_q.size());
    check("midrst_quiet", 32'(a_din_q.size() + d_din_q.size()), 32'd0);
    check("midrst_busy_after", 32'(busy), 32'd0);

    // Repeated register sequence; the first write after reset always addresses
    do_reset();
    push(8'h20, 8'h01);
    push(8'h20, 8'h02);
    push(8'h21, 8'h03);
    wait_idle(600, "rep_idle_timeout");
    $display("[TB] repeat-reg done: %0d address cycles, %0d data cycles", a_din_q.size(), d_din_q.size());
    check("rep_d_count", 32'(d_din_q.size()), 32'd3);
    if (d_din_q.size() == 3) begin
      check("rep_val0", 32'(d_din_q[0]), 32'h01);
      check("rep_val1", 32'(d_din_q[1]), 32'h02);
      check("rep_val2", 32'(d_din_q[2]), 32'h03);
    end
`ifdef JTOPLL_WRQ_SKIPADR_EN
    check("rep_a_count", 32'(a_din_q.size()), 32'd2);
    if (a_din_q.size() == 2) begin
      check("rep_reg0", 32'(a_din_q[0]), 32'h20);
      check("rep_reg1", 32'(a_din_q[1]), 32'h21);
    end
    if (d_cyc_q.size() == 3) check("rep_skip_space", 32'(d_cyc_q[1] - d_cyc_q[0]), 32'd87);
`else
    check("rep_a_count", 32'(a_din_q.size()), 32'd3);
    if (a_din_q.size() == 3) begin
      check("rep_reg0", 32'(a_din_q[0]), 32'h20);
      check("rep_reg1", 32'(a_din_q[1]), 32'h20);
      check("rep_reg2", 32'(a_din_q[2]), 32'h21);
    end
    if (d_cyc_q.size() == 3) check("rep_space", 32'(d_cyc_q[1] - d_cyc_q[0]), 32'd101);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtopll_wrq.md
Name: jtopll_wrq

Overview:
- Register-write queue and bus sequencer sitting directly upstream of the jtopll chip interface (din/addr/cs_n/wr_n).
- Accepts (register, value) pairs from a host over a valid/ready handshake and buffers them in a FIFO.
- Replays each pair on the OPLL bus as an address cycle followed by a data cycle.
- Inserts the wait times the YM2413 requires after each cycle, measured in cen ticks, so host software never polls or busy-waits.

Parameters:
- AW, 4, log2 of FIFO depth (depth = 2**AW entries).
- STROBE, 2, cen ticks that cs_n/wr_n are held low per bus cycle (≥1).
- ADDR_WAIT, 12, cen ticks idle after address-cycle strobe before the data cycle.
- DATA_WAIT, 84, cen ticks idle after data-cycle strobe before the next address cycle.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- cen  in  1  clock enable; same enable fed to jtopll.
- wr_reg  in  8  OPLL register number.
- wr_val  in  8  value to write.
- wr_valid  in  1  host request.
- wr_ready  out  1  FIFO not full; a push occurs when wr_valid & wr_ready at a clk edge.
- din  out  8  to jtopll din.
- addr  out  1  to jtopll addr (0 = address port, 1 = data port).
- cs_n  out  1  to jtopll cs_n.
- wr_n  out  1  to jtopll wr_n.
- busy  out  1  FSM not idle or FIFO non-empty.
- level  out  AW+1  FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset values: cs_n=1, wr_n=1, addr=0, din=0, wr_ready=0 during reset and 1 from the first cycle after release, busy=0, level=0, FSM=IDLE, FIFO flushed.
- FIFO push and level:
  - Push is on any clk edge, independent of cen.
  - wr_ready = (level < 2**AW), registered; there is no combinational bypass from pop to ready.
  - When full, wr_ready=0 and wr_valid is ignored. The host must hold its request, and nothing is dropped silently.
  - Simultaneous push and pop: level unchanged, both take effect.
- FSM: advances only on edges with cen=1. Outputs are registered.
  - IDLE: if level>0, pop the head into a {reg,val} holding register and go to ADR; otherwise stay.
  - ADR: addr=0, din=reg, cs_n=0, wr_n=0 for STROBE ticks, then AWAIT.
  - AWAIT: cs_n=1, wr_n=1, din held, for ADDR_WAIT ticks, then DAT.
  - DAT: addr=1, din=val, cs_n=0, wr_n=0 for STROBE ticks, then DWAIT.
  - DWAIT: cs_n=1, wr_n=1 for DATA_WAIT ticks, then IDLE.
- Tick counter: one counter, sized to hold max(STROBE, ADDR_WAIT, DATA_WAIT). It is loaded on state entry and decremented per cen tick. The exit transition happens on the tick where it reads 1.
- Timing with cen=1:
  - A push at edge t makes cs_n=0 after edge t+2.
  - Consecutive entries start every 1 + 2·STROBE + ADDR_WAIT + DATA_WAIT ticks (101 at defaults).
- cen=0: FSM, counter and bus outputs are frozen; FIFO push continues.
- rst_n low mid-transfer: at the next edge the bus is released (cs_n=wr_n=1), the FIFO is flushed and the in-flight write is abandoned.
- busy deasserts on the edge where DWAIT exits with the FIFO empty.

Optional Feature:
- Macro: JTOPLL_WRQ_SKIPADR_EN.
- Defined:
  - The block keeps last_reg plus a last_ok flag. last_ok is cleared by reset and set after any completed ADR cycle.
  - If the popped reg equals last_reg and last_ok=1, IDLE goes straight to DAT, skipping ADR and AWAIT.
  - Repeat writes to the same register then take 1 + STROBE + DATA_WAIT ticks (87 at defaults).
- Undefined: an address cycle is always issued, and last_reg/last_ok do not exist.

Decomposition:
- Package jtopll_wrq_pkg holds:
  - the state enum {IDLE, ADR, AWAIT, DAT, DWAIT};
  - default timing constants (STROBE=2, ADDR_WAIT=12, DATA_WAIT=84).
- One sub-module, jtopl_fifo: a generic synchronous FIFO with parameters DW=16 and AW, ports push/pop/dout/level/full/empty, and synchronous active-low reset. It is reusable by other jtopl queues.

Test Plan:
- Single write reg=0x10 val=0x5A, cen=1:
  - cs_n low with addr=0, din=0x10 for 2 cycles.
  - 12 cycles later, cs_n low with addr=1, din=0x5A for 2 cycles.
  - busy drops after 84 more cycles.
- Burst of 17 pushes with AW=4:
  - wr_ready=0 after the 16th push is accepted (the 17th is stalled until the first pop).
  - Bus order matches push order.
  - Address strobes are 101 cycles apart.
- cen toggling 1-of-4:
  - All phase durations scale ×4.
  - Pushes while cen=0 are still accepted and level increments.
- rst_n pulsed low during DWAIT of write 1 with 3 entries queued:
  - Next cycle cs_n=1, level=0, busy=0.
  - No further bus activity.
- JTOPLL_WRQ_SKIPADR_EN defined, writes (0x20,0x01),(0x20,0x02),(0x21,0x03):
  - The second write issues no addr=0 cycle; the third does.
  - The first write after reset always issues an address cycle.
- Simultaneous push and pop at level=16 (full):
  - Push ignored because wr_ready=0 that cycle.
  - level becomes 15, and wr_ready=1 on the following cycle.
